// File: rtl/adder_nbit_seq.sv
// -----------------------------------------------------------------------------
// adder_nbit_seq
//
// Sequential (slice-serial) two's-complement adder/subtractor. One SLICE-bit
// chunk of the operands is added per clock, least significant chunk first. The
// carry between chunks is kept in a carry register. An operation of
// WIDTH/SLICE slices produces a one-cycle done pulse. The pulse appears in the
// cycle after the last slice edge.
//
// Parameters
//   WIDTH     operand/result width in bits (must be a multiple of SLICE)
//   SLICE     bits added per clock (SLICE == WIDTH gives a single RUN cycle)
//
// Ports
//   clk        in   rising-edge clock
//   reset      in   synchronous, active-high; aborts any operation
//   start      in   begin an operation (accepted in IDLE and DONE, ignored in RUN)
//   sub        in   0 = value1 + value2 + carry_in, 1 = value1 - value2
//   value1     in   first operand
//   value2     in   second operand
//   carry_in   in   carry into bit 0 (add only)
//   busy       out  operation in progress
//   done       out  one-cycle pulse, result outputs updated this cycle
//   sum        out  result, holds until the next done
//   carry_out  out  carry out of the MSB (subtract: 1 = no borrow)
//   overflow   out  signed overflow
//   zero       out  sum == 0 (carry_out not included)
// -----------------------------------------------------------------------------
module adder_nbit_seq #(
   parameter int WIDTH = 32,
   parameter int SLICE = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic             sub,
   input  logic [WIDTH-1:0] value1,
   input  logic [WIDTH-1:0] value2,
   input  logic             carry_in,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] sum,
   output logic             carry_out,
   output logic             overflow,
   output logic             zero
);

   localparam int NSLICE = WIDTH / SLICE;
   localparam int IDX_W  = (NSLICE > 1) ? $clog2(NSLICE) : 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NSLICE - 1);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_RUN  = 2'd1;
   localparam logic [1:0] S_DONE = 2'd2;

   logic [1:0]       state_reg;
   logic [IDX_W-1:0] idx_reg;
   logic [WIDTH-1:0] a_reg;     // operand A, shifted right one slice per cycle
   logic [WIDTH-1:0] b_reg;     // operand B (already inverted for subtract)
   logic [WIDTH-1:0] acc_reg;   // partial sum, filled from the top down
   logic             carry_reg;

   // The slice being added always sits in the low SLICE bits of a_reg/b_reg.
   logic [SLICE:0]   slice_total;
   logic [WIDTH-1:0] acc_next;
   logic             msb_carry_in;
   logic             overflow_next;

   always_comb begin
      slice_total = {1'b0, a_reg[SLICE-1:0]} + {1'b0, b_reg[SLICE-1:0]}
                  + {{SLICE{1'b0}}, carry_reg};
      // Each new slice enters at the top and earlier slices move down. After
      // NSLICE steps the first slice has reached bit 0.
      acc_next = (acc_reg >> SLICE)
               | (WIDTH'(slice_total[SLICE-1:0]) << (WIDTH - SLICE));
      // On the final slice, its top bit is bit WIDTH-1 of the result. The carry
      // into that bit is recovered from the bit's own sum: s = a ^ b ^ cin.
      msb_carry_in  = a_reg[SLICE-1] ^ b_reg[SLICE-1] ^ slice_total[SLICE-1];
      overflow_next = msb_carry_in ^ slice_total[SLICE];
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg <= S_IDLE;
         idx_reg   <= '0;
         a_reg     <= '0;
         b_reg     <= '0;
         acc_reg   <= '0;
         carry_reg <= 1'b0;
         busy      <= 1'b0;
         done      <= 1'b0;
         sum       <= '0;
         carry_out <= 1'b0;
         overflow  <= 1'b0;
         zero      <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state_reg)
            // DONE accepts start exactly like IDLE, so ops can run back to back.
            S_IDLE, S_DONE: begin
               if (start) begin
                  a_reg     <= value1;
                  b_reg     <= sub ? ~value2 : value2;
                  carry_reg <= sub ? 1'b1 : carry_in;
                  acc_reg   <= '0;
                  idx_reg   <= '0;
                  busy      <= 1'b1;
                  state_reg <= S_RUN;
               end else begin
                  state_reg <= S_IDLE;
               end
            end
            S_RUN: begin
               a_reg     <= a_reg >> SLICE;
               b_reg     <= b_reg >> SLICE;
               carry_reg <= slice_total[SLICE];
               acc_reg   <= acc_next;
               idx_reg   <= idx_reg + IDX_W'(1);
               if (idx_reg == LAST_IDX) begin
                  // Result outputs change only here, so partial sums stay hidden.
                  state_reg <= S_DONE;
                  busy      <= 1'b0;
                  done      <= 1'b1;
                  sum       <= acc_next;
                  carry_out <= slice_total[SLICE];
                  overflow  <= overflow_next;
                  zero      <= (acc_next == '0);
               end
            end
            default: begin
               state_reg <= S_IDLE;
               busy      <= 1'b0;
            end
         endcase
      end
   end

endmodule
